// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART definitions: transmitter state encoding, data width and
// frame length. Kept separate so the receiver can reuse the same constants.
// No ports (package).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DATA_BITS       = 8;
    // start + 8 data + stop
    localparam int unsigned FRAME_BITS_BASE = 10;

    // Bit periods per frame, including the optional parity bit.
    function automatic int unsigned frame_bits(input bit parity_en);
        return FRAME_BITS_BASE + (parity_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick_gen.sv
// BaudTickGen
// Fractional-accumulator baud strobe. Each enabled clock adds
// Baud*Oversampling to the accumulator; when the sum reaches ClkFrequency a
// one-cycle tick is issued and ClkFrequency is subtracted, so the remainder
// carries over and the long-run rate has no drift.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   enable in   run the generator; low re-seeds the accumulator to zero
//   tick   out  one-cycle strobe, ClkFrequency/(Baud*Oversampling) clocks apart
module BaudTickGen #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int Inc      = Baud * Oversampling;
    localparam int AccWidth = $clog2(ClkFrequency + Inc + 1);

    localparam logic [AccWidth-1:0] IncV = AccWidth'(Inc);
    localparam logic [AccWidth-1:0] ModV = AccWidth'(ClkFrequency);

    logic [AccWidth-1:0] acc;
    logic [AccWidth-1:0] acc_next;

    // acc stays below ModV, so acc + IncV always fits in AccWidth bits.
    assign acc_next = acc + IncV;
    assign tick     = enable && (acc_next >= ModV);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc <= '0;
        end else if (tick) begin
            acc <= acc_next - ModV;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 (or 8E1 with PARITY_EN=1) UART transmitter, LSB first.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_start  in   send request, only looked at in IDLE
//   tx_data   in   [7:0] byte to send, captured on acceptance
//   tx_busy   out  high from the cycle after acceptance until the frame ends
//   tx_done   out  one-cycle pulse in the first IDLE cycle after the stop bit
//   txd       out  serial line, idles high
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | line high, waiting for tx_start
// ST_START  | start bit (txd=0)
// ST_DATA   | data bit bit_idx (0..7), taken from shreg[0]
// ST_PARITY | even parity over the 8 data bits (PARITY_EN only)
// ST_STOP   | stop bit (txd=1); tick returns to IDLE with tx_done
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD          = 115200,
    parameter int PARITY_EN     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        baud_en;
    logic        baud_tick;

    // Generator runs only during a frame, so the first tick lands one full
    // bit period after START is entered.
    assign baud_en = (state != ST_IDLE);

    BaudTickGen #(
        .ClkFrequency (CLK_FREQUENCY),
        .Baud         (BAUD),
        .Oversampling (1)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (baud_en),
        .tick   (baud_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shreg   <= tx_data;
                        state   <= ST_START;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                txd   <= ^shreg;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[1];
                        end
                        // Rotate rather than shift: the byte stays intact for
                        // parity, and eight rotations restore it.
                        shreg <= {shreg[0], shreg[7:1]};
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        state   <= ST_IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Two transmitters on one clock: u_dut0 without parity, u_dut1 with parity.
// Expected bytes are queued when a send is requested; a line monitor per
// transmitter decodes each frame at mid-bit and checks it against the queue.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLKF   = 1000000;
    localparam int BAUDR  = 100000;
    localparam int BITCLK = CLKF / BAUDR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       busy0, busy1, done0, done1, txd0, txd1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int nd0   = 0;
    int nd1   = 0;
    int base;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_tx #(.CLK_FREQUENCY(CLKF), .BAUD(BAUDR), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_start(start0), .tx_data(data0),
        .tx_busy(busy0), .tx_done(done0), .txd(txd0)
    );

    uart_tx #(.CLK_FREQUENCY(CLKF), .BAUD(BAUDR), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_data(data1),
        .tx_busy(busy1), .tx_done(done1), .txd(txd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0 === 1'b1) nd0++;
        if (done1 === 1'b1) nd1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic txd_of(input int w);
        return (w == 1) ? txd1 : txd0;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 1) ? busy1 : busy0;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 1) ? done1 : done0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait n falling edges; flags (and stops waiting) if reset is seen.
    task automatic wait_neg(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            if (ab) return;
            @(negedge clk);
            if (rst === 1'b1) ab = 1'b1;
        end
    endtask

    task automatic wait_idle(input int w, input int maxc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_of(w) !== 1'b0 && k < maxc);
        chk($sformatf("idle_wait%0d", w), busy_of(w), 0);
    endtask

    task automatic monitor(input int w);
        int         s, d, nb, qsz;
        bit         ab, seen;
        logic       st, p, sp, bz;
        logic [7:0] b, e;
        nb = int'(frame_bits(w == 1));
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || txd_of(w) !== 1'b0) continue;
            s  = cyc;
            ab = 1'b0;
            p  = 1'b0;
            wait_neg(BITCLK / 2 - 1, ab);
            st = txd_of(w);
            for (int i = 0; i < 8; i++) begin
                wait_neg(BITCLK, ab);
                b[i] = txd_of(w);
            end
            if (w == 1) begin
                wait_neg(BITCLK, ab);
                p = txd_of(w);
            end
            wait_neg(BITCLK, ab);
            sp = txd_of(w);
            if (ab) continue;
            seen = 1'b0;
            d    = 0;
            bz   = 1'b1;
            for (int k = 0; k < BITCLK; k++) begin
                @(negedge clk);
                if (done_of(w) === 1'b1) begin
                    seen = 1'b1;
                    d    = cyc;
                    bz   = busy_of(w);
                    break;
                end
            end
            chk($sformatf("rx%0d_done_seen", w), seen, 1);
            chk($sformatf("rx%0d_frame_clocks", w), d - s, nb * BITCLK);
            chk($sformatf("rx%0d_busy_at_done", w), bz, 0);
            chk($sformatf("rx%0d_start_bit", w), st, 0);
            chk($sformatf("rx%0d_stop_bit", w), sp, 1);
            qsz = (w == 1) ? q1.size() : q0.size();
            chk($sformatf("rx%0d_frame_expected", w), (qsz != 0), 1);
            if (qsz != 0) begin
                e = (w == 1) ? q1.pop_front() : q0.pop_front();
                chk($sformatf("rx%0d_data", w), b, e);
                if (w == 1) chk("rx1_parity", p, ^e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, k;
        logic lv;

        fork
            monitor(0);
            monitor(1);
        join_none

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_txd0", txd0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_txd1", txd1, 1);
        chk("rst_busy1", busy1, 0);

        // tx_start on the last reset edge is ignored; the next edge accepts it
        start0 = 1'b1;
        data0  = 8'h55;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_edge_start_busy", busy0, 0);
        chk("rst_edge_start_txd", txd0, 1);
        q0.push_back(8'h55);
        tick();
        start0 = 1'b0;
        data0  = 8'h00;
        @(negedge clk);
        chk("accept_busy", busy0, 1);
        chk("accept_txd", txd0, 0);

        // 0x55 toggles every bit: measure start..D7 level durations
        for (int i = 0; i < 9; i++) begin
            lv  = txd0;
            len = 0;
            do begin
                @(negedge clk);
                len++;
            end while (txd0 === lv && len < 3 * BITCLK);
            chk($sformatf("bit%0d_clocks_ok", i), (len >= BITCLK - 1 && len <= BITCLK + 1), 1);
        end
        wait_idle(0, 3 * BITCLK);
        repeat (3) @(negedge clk);
        chk("done_count_55", nd0, 1);

        // Parity frame 0x07
        data1  = 8'h07;
        start1 = 1'b1;
        q1.push_back(8'h07);
        tick();
        start1 = 1'b0;
        @(negedge clk);
        chk("par_accept_busy", busy1, 1);
        wait_idle(1, 15 * BITCLK);
        repeat (3) @(negedge clk);
        chk("done_count_par", nd1, 1);

        // tx_start during a frame is ignored
        base   = nd0;
        data0  = 8'hA3;
        start0 = 1'b1;
        q0.push_back(8'hA3);
        tick();
        start0 = 1'b0;
        repeat (35) tick();
        data0  = 8'hFF;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        data0  = 8'h00;
        wait_idle(0, 15 * BITCLK);
        repeat (30) @(negedge clk);
        chk("ignored_start_no_frame", busy0, 0);
        chk("ignored_start_done_count", nd0 - base, 1);

        // Held tx_start: back-to-back 0x12 then 0x34
        base   = nd0;
        data0  = 8'h12;
        start0 = 1'b1;
        q0.push_back(8'h12);
        tick();
        data0 = 8'h34;
        q0.push_back(8'h34);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done0 !== 1'b1 && k < 15 * BITCLK);
        chk("b2b_first_done", done0, 1);
        tick();
        start0 = 1'b0;
        data0  = 8'h00;
        @(negedge clk);
        chk("b2b_next_start_txd", txd0, 0);
        chk("b2b_next_start_busy", busy0, 1);
        wait_idle(0, 15 * BITCLK);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", nd0 - base, 2);

        // Reset in DATA(3) abandons the frame
        base   = nd0;
        data0  = 8'h3C;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4 * BITCLK + 4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_txd", txd0, 1);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        tick();
        rst = 1'b0;
        repeat (12 * BITCLK) @(negedge clk);
        chk("midrst_no_done", nd0 - base, 0);
        chk("midrst_line_idle", txd0, 1);
        data0  = 8'h81;
        start0 = 1'b1;
        q0.push_back(8'h81);
        tick();
        start0 = 1'b0;
        wait_idle(0, 15 * BITCLK);
        repeat (3) @(negedge clk);
        chk("postrst_done_count", nd0 - base, 1);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after D7.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-007 SHALL have port tx_data  input  8  byte to send, LSB first; captured on acceptance.
REQ-008 SHALL have port tx_busy  output  1  high from the cycle after acceptance until the frame ends.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at the end of the stop bit.
REQ-010 SHALL have port txd  output  1  serial line output; idle level 1.

Function
REQ-011 SHALL use a single clock domain with a synchronous, active-high reset; no other clocks or asynchronous resets.
REQ-012 SHALL accept a request when state==IDLE and tx_start==1, latching tx_data into a shift register in that cycle.
REQ-013 SHALL ignore tx_start while tx_busy==1, with no queueing and no corruption of the frame in flight.
REQ-014 SHALL use states IDLE, START, DATA (bit index 0..7), PARITY (only if PARITY_EN), STOP.
REQ-015 SHALL enter START on the cycle after acceptance and drive txd=0 from that cycle.
REQ-016 SHALL advance state only on a baud tick: START->DATA(0); DATA(i)->DATA(i+1); DATA(7)->PARITY or STOP; PARITY->STOP; STOP->IDLE.
REQ-017 SHALL drive txd from a register: 0 in START, tx_data[i] in DATA(i), XOR of all 8 data bits in PARITY, and 1 in STOP and IDLE.
REQ-018 SHALL enable the baud tick generator exactly while state!=IDLE, so it re-seeds in IDLE and the first tick arrives about one bit period after START is entered.
REQ-019 SHALL hold each bit for CLK_FREQUENCY/BAUD clocks, +/-1 clock from accumulator quantisation, with no cumulative drift beyond 2% over a frame.
REQ-020 SHALL pulse tx_done for exactly one cycle, in the first IDLE cycle after STOP, with tx_busy low in that cycle.
REQ-021 SHALL accept a tx_start in the same cycle as tx_done, so back-to-back frames have no extra idle bit.
REQ-022 SHALL derive tx_busy directly from the state (state!=IDLE), registered, with no combinational path from tx_start.
REQ-023 SHALL have a frame length of 10 bit periods, or 11 when PARITY_EN=1.

Reset
REQ-024 SHALL, while rst==1, force state=IDLE, txd=1, tx_busy=0, tx_done=0, shift register and bit index to 0, and the tick accumulator to its re-seed value.
REQ-025 SHALL, if rst is asserted mid-frame, drive txd=1 from the next cycle and abandon the frame without a tx_done pulse.
REQ-026 SHALL accept a tx_start in the first cycle after rst deasserts.

Structure
REQ-027 SHALL place the state encoding constants and the frame-length constant in a shared uart_pkg package, for reuse by the future receiver.
REQ-028 SHALL instantiate the existing BaudTickGen sub-module with Oversampling=1, enable=(state!=IDLE), and tick consumed as the bit strobe.
REQ-029 SHALL contain all control in one FSM plus a 3-bit index and an 8-bit shift register, with no FIFO.

Verification
REQ-030 SHALL verify, with CLK_FREQUENCY=1000000, BAUD=100000 and tx_data=0x55 pulsed: txd bits sampled at mid-bit are 0,1,0,1,0,1,0,1,0,1; 10 bits at 10+/-1 clocks each; one tx_done.
REQ-031 SHALL verify, with PARITY_EN=1 and tx_data=0x07: the parity bit is 1 and the frame is 11 bits with the stop bit at 1.
REQ-032 SHALL verify that tx_start pulsed with 0xFF during an 0xA3 frame leaves the frame as 0xA3 and produces exactly one tx_done.
REQ-033 SHALL verify that tx_start=1 held continuously with 0x12 then 0x34 gives back-to-back frames with the next start bit immediately after the stop bit.
REQ-034 SHALL verify that rst asserted during DATA(3) gives txd=1 on the next cycle, tx_busy=0, no tx_done, and a clean frame on a new tx_start.
REQ-035 SHALL verify that asserting tx_start in the cycle rst deasserts produces no frame, and asserting it one cycle later produces a correct frame.
